// File: rtl/mbist_pkg.sv
// Shared definitions for the March C- memory BIST: FSM states and the march element table.
package mbist_pkg;

  localparam int NUM_ELEM = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // One march element. A two-op element always reads first, then writes.
  typedef struct packed {
    logic down;    // 1: addresses count from the top down to 0
    logic has_rd;  // element contains a read
    logic has_wr;  // element contains a write
    logic rd_val;  // expected read value: 0 -> BG, 1 -> ~BG
    logic wr_val;  // written value:       0 -> BG, 1 -> ~BG
  } elem_t;

  // March C-: {w0} up(r0,w1) up(r1,w0) down(r0,w1) down(r1,w0) {r0}
  function automatic elem_t elem_info(input logic [2:0] idx);
    elem_t e;
    e = '0;
    case (idx)
      3'd0: e = '{down: 1'b0, has_rd: 1'b0, has_wr: 1'b1, rd_val: 1'b0, wr_val: 1'b0};
      3'd1: e = '{down: 1'b0, has_rd: 1'b1, has_wr: 1'b1, rd_val: 1'b0, wr_val: 1'b1};
      3'd2: e = '{down: 1'b0, has_rd: 1'b1, has_wr: 1'b1, rd_val: 1'b1, wr_val: 1'b0};
      3'd3: e = '{down: 1'b1, has_rd: 1'b1, has_wr: 1'b1, rd_val: 1'b0, wr_val: 1'b1};
      3'd4: e = '{down: 1'b1, has_rd: 1'b1, has_wr: 1'b1, rd_val: 1'b1, wr_val: 1'b0};
      3'd5: e = '{down: 1'b0, has_rd: 1'b1, has_wr: 1'b0, rd_val: 1'b0, wr_val: 1'b0};
      default: e = '0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/mbist_addr_gen.sv
// Up/down address generator. The internal count always runs 0..max; a down
// element sees the bitwise inverse, so "last" never depends on direction.
module mbist_addr_gen #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              step,
  input  logic              dir,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // Next count: clear has priority over step.
  always_comb begin
    // NOTE: assign a default first so every path drives cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (step) begin
      cnt_d = cnt_q + ADDR_W'(1);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign addr = dir ? ~cnt_q : cnt_q;
  assign last = &cnt_q;

endmodule

// File: rtl/mbist_march.sv
// March C- memory BIST controller with normal-mode SRAM pass-through and
// sticky failure logging (first failing address/element, saturating count).
module mbist_march
  import mbist_pkg::*;
#(
  parameter int               ADDR_W = 6,
  parameter int               DATA_W = 8,
  parameter logic [DATA_W-1:0] BG    = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              csin,
  input  logic              rwbarin,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] datain,
  output logic              ram_cs,
  output logic              ram_rwbar,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic [7:0]        fail_cnt
);

  state_e            state_q, state_d;
  logic [2:0]        elem_q, elem_d;
  logic              phase_q, phase_d;
  logic              pend_q, pend_d;
  logic [DATA_W-1:0] exp_q, exp_d;
  logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
  logic [2:0]        cmp_elem_q, cmp_elem_d;
  logic              fail_q, fail_d;
  logic [7:0]        fail_cnt_q, fail_cnt_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [2:0]        fail_elem_q, fail_elem_d;

  elem_t             cur;
  logic              op_rd, addr_done, start_ok, abort_hit, mismatch;
  logic              gen_clear, gen_step, gen_last;
  logic [ADDR_W-1:0] gen_addr;

  assign cur       = elem_info(elem_q);
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);
  assign op_rd     = !phase_q && cur.has_rd;
  assign addr_done = phase_q || !(cur.has_rd && cur.has_wr);
  assign start_ok  = start && !busy;
  assign abort_hit = abort && busy;

  mbist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (gen_clear),
    .step  (gen_step),
    .dir   (cur.down),
    .addr  (gen_addr),
    .last  (gen_last)
  );

  // Sequencer: state, element and op phase; drives the address generator.
  always_comb begin
    state_d   = state_q;
    elem_d    = elem_q;
    phase_d   = phase_q;
    gen_clear = 1'b0;
    gen_step  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_RUN;
          elem_d    = '0;
          phase_d   = 1'b0;
          gen_clear = 1'b1;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (!addr_done) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (gen_last) begin
            gen_clear = 1'b1;
            if (elem_q == 3'(NUM_ELEM - 1)) begin
              state_d = ST_DRAIN;
            end else begin
              elem_d = elem_q + 3'd1;
            end
          end else begin
            gen_step = 1'b1;
          end
        end
      end
      ST_DRAIN: state_d = abort ? ST_IDLE : ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // SRAM port mux: test values while busy (and not in reset), otherwise pass-through.
  always_comb begin
    ram_cs    = csin;
    ram_rwbar = rwbarin;
    ram_addr  = address;
    ram_din   = datain;
    if (busy && rst) begin
      ram_cs    = 1'b1;
      ram_rwbar = (state_q == ST_DRAIN) || op_rd;
      ram_addr  = gen_addr;
      ram_din   = cur.wr_val ? ~BG : BG;
    end
  end

  // Read pipeline and failure log: compare one cycle after each test read.
  always_comb begin
    pend_d      = (state_q == ST_RUN) && op_rd && !abort;
    exp_d       = cur.rd_val ? ~BG : BG;
    cmp_addr_d  = gen_addr;
    cmp_elem_d  = elem_q;
    mismatch    = pend_q && !abort_hit && (ram_dout != exp_q);
    fail_d      = fail_q;
    fail_cnt_d  = fail_cnt_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    if (start_ok) begin
      fail_d      = 1'b0;
      fail_cnt_d  = '0;
      fail_addr_d = '0;
      fail_elem_d = '0;
    end else if (mismatch) begin
      fail_d = 1'b1;
      if (fail_cnt_q != 8'hFF) begin
        fail_cnt_d = fail_cnt_q + 8'd1;
      end
      if (!fail_q) begin
        fail_addr_d = cmp_addr_q;
        fail_elem_d = cmp_elem_q;
      end
    end
  end

  // All controller registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      elem_q      <= '0;
      phase_q     <= 1'b0;
      pend_q      <= 1'b0;
      exp_q       <= '0;
      cmp_addr_q  <= '0;
      cmp_elem_q  <= '0;
      fail_q      <= 1'b0;
      fail_cnt_q  <= '0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      phase_q     <= phase_d;
      pend_q      <= pend_d;
      exp_q       <= exp_d;
      cmp_addr_q  <= cmp_addr_d;
      cmp_elem_q  <= cmp_elem_d;
      fail_q      <= fail_d;
      fail_cnt_q  <= fail_cnt_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
    end
  end

  assign fail      = fail_q;
  assign fail_cnt  = fail_cnt_q;
  assign fail_addr = fail_addr_q;
  assign fail_elem = fail_elem_q;

endmodule

// File: tb/tb_mbist_march.sv
// Directed bench for mbist_march with a behavioural SRAM that can inject faults.
module tb_mbist_march;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, abort = 1'b0;
  logic       csin = 1'b0, rwbarin = 1'b1;
  logic [5:0] address = '0;
  logic [7:0] datain = '0;
  logic       ram_cs, ram_rwbar;
  logic [5:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout = '0;
  logic       busy, done, fail;
  logic [5:0] fail_addr;
  logic [2:0] fail_elem;
  logic [7:0] fail_cnt;

  int n_vec = 0;
  int n_miss = 0;
  int ncyc;

  logic [7:0] mem [64];
  logic [7:0] rd_v;
  logic       stuck_en = 1'b0;
  logic       corrupt  = 1'b0;

  always #5 clk = ~clk;

  mbist_march dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .csin(csin), .rwbarin(rwbarin), .address(address), .datain(datain),
    .ram_cs(ram_cs), .ram_rwbar(ram_rwbar), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .busy(busy), .done(done), .fail(fail),
    .fail_addr(fail_addr), .fail_elem(fail_elem), .fail_cnt(fail_cnt)
  );

  // Synchronous SRAM: read data appears the cycle after the read is issued.
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_rwbar) begin
        rd_v = mem[ram_addr];
        if (stuck_en && ram_addr == 6'h15) rd_v[0] = 1'b1;
        if (corrupt) rd_v = ~rd_v;
        ram_dout <= rd_v;
      end else begin
        mem[ram_addr] <= ram_din;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic skip(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the bench at the negedge of run cycle 0.
  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    // Reset state and normal-mode pass-through
    skip(2);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fail", fail, 0);
    check("rst_fail_cnt", fail_cnt, 0);
    check("rst_fail_addr", fail_addr, 0);
    check("rst_fail_elem", fail_elem, 0);
    rst = 1'b1;
    csin = 1'b1; rwbarin = 1'b0; address = 6'h2a; datain = 8'h5c;
    skip(1);
    check("pass_cs", ram_cs, 1);
    check("pass_rwbar", ram_rwbar, 0);
    check("pass_addr", ram_addr, 6'h2a);
    check("pass_din", ram_din, 8'h5c);
    csin = 1'b0; rwbarin = 1'b1;

    // Good SRAM: op sequence spot checks and run length
    pulse_start();
    check("c0_cs", ram_cs, 1);
    check("c0_w0", {ram_rwbar, ram_addr, ram_din}, {1'b0, 6'd0, 8'h00});
    skip(64);
    check("c64_e1_r0", {ram_rwbar, ram_addr}, {1'b1, 6'd0});
    skip(1);
    check("c65_e1_w1", {ram_rwbar, ram_addr, ram_din}, {1'b0, 6'd0, 8'hFF});
    skip(255);
    check("c320_e3_r0_top", {ram_rwbar, ram_addr}, {1'b1, 6'd63});
    skip(319);
    check("c639_e5_r0", {ram_rwbar, ram_addr}, {1'b1, 6'd63});
    count_busy(ncyc);
    check("good_len", 639 + ncyc, 641);
    check("good_done", done, 1);
    check("good_fail", fail, 0);
    check("good_cnt", fail_cnt, 0);
    skip(5);
    check("done_held", done, 1);

    // Bit 0 stuck-at-1 at 0x15
    stuck_en = 1'b1;
    pulse_start();
    count_busy(ncyc);
    check("stuck_len", ncyc, 641);
    check("stuck_fail", fail, 1);
    check("stuck_addr", fail_addr, 6'h15);
    check("stuck_elem", fail_elem, 1);
    check("stuck_cnt", fail_cnt, 3);
    stuck_en = 1'b0;

    // Extra start pulses during RUN are ignored; start cleared the old log
    pulse_start();
    skip(10);
    start = 1'b1; skip(1); start = 1'b0;
    skip(289);
    start = 1'b1; skip(1); start = 1'b0;
    count_busy(ncyc);
    check("restart_len", 301 + ncyc, 641);
    check("restart_done", done, 1);
    check("restart_fail_cleared", fail, 0);

    // Abort (with start in the same cycle) at cycle 200, faulty SRAM
    stuck_en = 1'b1;
    pulse_start();
    csin = 1'b1; rwbarin = 1'b1; address = 6'h33; datain = 8'ha5;
    skip(200);
    abort = 1'b1; start = 1'b1;
    skip(1);
    abort = 1'b0; start = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_pass", {ram_cs, ram_rwbar, ram_addr, ram_din}, {1'b1, 1'b1, 6'h33, 8'ha5});
    check("abort_keep_fail", fail, 1);
    check("abort_keep_cnt", fail_cnt, 1);
    check("abort_keep_addr", fail_addr, 6'h15);
    csin = 1'b0;
    skip(3);
    check("abort_stays_idle", busy, 0);

    // Reset held one cycle during E3
    pulse_start();
    skip(350);
    check("e3_busy", busy, 1);
    rst = 1'b0;
    #1;
    check("rst_pass_cs", ram_cs, 0);
    skip(1);
    rst = 1'b1;
    check("rst_run_busy", busy, 0);
    check("rst_run_done", done, 0);
    check("rst_run_fail", fail, 0);
    check("rst_run_cnt", fail_cnt, 0);
    check("rst_run_faddr", fail_addr, 0);
    check("rst_run_felem", fail_elem, 0);
    stuck_en = 1'b0;
    pulse_start();
    count_busy(ncyc);
    check("post_rst_len", ncyc, 641);
    check("post_rst_done", done, 1);
    check("post_rst_fail", fail, 0);

    // Every read corrupted: count saturates
    corrupt = 1'b1;
    pulse_start();
    count_busy(ncyc);
    check("sat_len", ncyc, 641);
    check("sat_done", done, 1);
    check("sat_cnt", fail_cnt, 255);
    check("sat_elem", fail_elem, 1);
    check("sat_addr", fail_addr, 0);
    corrupt = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
